piso_bit_serializer: RTL and testbench
======================================

Name: piso_bit_serializer

Overview:
Parallel-in, serial-out stage that feeds the team's serial sequence-detector FSMs. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on x_out, which drives the detector's X input directly. Supports MSB-first or LSB-first order, selected per word. An optional inter-word idle gap gives the downstream FSM a known quiet level between words.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
GAP, 0, idle cycles inserted after each word; legal range GAP >= 0.
IDLE_LEVEL, 1'b0, value driven on x_out whenever no data bit is being shifted.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din is valid this cycle.
din_ready  output  1  block can accept a word this cycle.
msb_first  input  1  bit order for the word being accepted; 1 = bit WIDTH-1 goes out first.
x_out  output  1  serial bit stream to the downstream detector.
x_valid  output  1  x_out carries a data bit this cycle.
word_done  output  1  one-cycle pulse coinciding with the last bit of a word.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; shift register = 0; bit counter = 0; gap counter = 0; stored order flag = 1.
  - Outputs: x_out = IDLE_LEVEL, x_valid = 0, word_done = 0, busy = 0, din_ready = 1.
- States:
  - IDLE: din_ready = 1. A word is accepted when din_valid & din_ready at a posedge. On accept: load din into the shift register, capture msb_first, clear the bit counter, go to SHIFT.
  - SHIFT: x_valid = 1.
    - x_out = shreg[WIDTH-1] if the captured order flag = 1, else shreg[0].
    - Each cycle, shift toward the output end (zero fill) and increment the bit counter.
    - Exactly WIDTH cycles are spent in SHIFT per word.
    - word_done = 1 in the cycle the counter equals WIDTH-1.
  - GAP: x_out = IDLE_LEVEL, x_valid = 0, din_ready = 0. Lasts exactly GAP cycles, then go to IDLE.
- Last-bit transition (bit counter = WIDTH-1):
  - GAP > 0: go to GAP.
  - GAP = 0: din_ready = 1 in this cycle.
    - If din_valid = 1: load the new word and stay in SHIFT. The stream is seamless, with no idle bit between words.
    - Otherwise: go to IDLE.
- din_ready = (state == IDLE) | (state == SHIFT & last bit & GAP == 0).
- Outputs are decoded from registered state only; no combinational path from din or din_valid to x_out or x_valid.
- Latency: the first bit of an accepted word appears on x_out in the cycle after the accepting edge.
- Handshake boundaries:
  - din and msb_first are ignored when no handshake occurs.
  - din_valid held high while din_ready = 0 causes no accept. The word is taken at the first cycle din_ready = 1.
  - msb_first changes mid-word have no effect on the word in flight.
- Reset mid-word: the word is discarded with no word_done, and outputs go to their reset values at once. After release, the block behaves as from power-up.
- Counter widths:
  - Bit counter: $clog2(WIDTH) bits.
  - Gap counter: $clog2(GAP+1) bits, minimum 1 bit.
  - Neither counter may wrap within a word.

Decomposition:
- Shared package:
  - state encoding typedef {IDLE, SHIFT, GAP} (2-bit);
  - IDLE_LEVEL default constant;
  - helper constant for the counter-width calculation.
- One natural sub-module: terminal_counter.
  - Parameterised modulo-N up-counter with enable, sync clear and async rst.
  - Provides a terminal-count flag.
  - Instanced twice: bit counter (N = WIDTH) and gap counter (N = GAP).
  - Omit the gap instance by generate when GAP = 0.
- The remaining logic is the top-level FSM plus the shift register.

Test Plan:
1. WIDTH=8, GAP=0. Accept din=8'hE5 with msb_first=1.
   - x_out over the next 8 cycles = 1,1,1,0,0,1,0,1, with x_valid=1 throughout.
   - word_done high on the 8th cycle only.
   - Then x_out=0, x_valid=0, busy=0.
2. Accept din=8'h07 with msb_first=0.
   - x_out = 1,1,1,0,0,0,0,0 (three leading ones, then zeros).
   - msb_first toggled mid-word does not alter the sequence.
3. GAP=0 back-to-back. din_valid held high with 8'hFF then 8'h00.
   - din_ready=1 on bit 8 of the first word.
   - 16 consecutive x_valid cycles: eight 1s, then eight 0s, with no idle bit between them.
4. GAP=2, din_valid held high.
   - After each word, x_out=IDLE_LEVEL and din_ready=0 for exactly 2 cycles.
   - Then one IDLE cycle accepts the next word; its first bit appears the cycle after.
5. Reset mid-word: assert rst asynchronously during bit 4 of 8'hE5.
   - Outputs go immediately to x_out=0, x_valid=0, word_done=0, busy=0, din_ready=1.
   - After release, a fresh 8'h0F msb-first produces 0,0,0,0,1,1,1,1.
6. din_valid pulsed while busy (SHIFT, not last bit) with din=8'hAA.
   - No accept occurs; the in-flight word is unchanged.
   - Holding din_valid causes the accept at the first ready cycle.

Source files
------------

// File: rtl/piso_bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// State encoding, idle level default, counter width helper.
package piso_bit_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // Width for a counter holding values 0..n-1, at least 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/terminal_counter.sv
// Modulo-N up-counter with enable, sync clear, async reset.
// Ports: clk, rst, clr, en in; tc out (count == N-1).
module terminal_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out stage feeding serial detector FSMs.
// Ports: clk, rst, din/din_valid/din_ready, msb_first in;
// x_out, x_valid, word_done, busy out.
module piso_bit_serializer
  import piso_bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             msb_first,
  output logic             x_out,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shreg;
  logic             order;
  logic             bit_tc;
  logic             gap_tc;
  logic             in_idle;
  logic             in_shift;
  logic             last_bit;
  logic             accept;

  assign in_idle  = (state == S_IDLE);
  assign in_shift = (state == S_SHIFT);
  assign last_bit = in_shift & bit_tc;

  // Seamless back-to-back loading only without a gap.
  assign din_ready = in_idle | (last_bit & (GAP == 0));
  assign accept    = din_valid & din_ready;

  terminal_counter #(
    .N(WIDTH),
    .W(cnt_w(WIDTH))
  ) u_bit_cnt (
    .clk(clk),
    .rst(rst),
    .clr(in_idle),
    .en (in_shift),
    .tc (bit_tc)
  );

  generate
    if (GAP > 0) begin : g_gap
      terminal_counter #(
        .N(GAP),
        .W(cnt_w(GAP + 1))
      ) u_gap_cnt (
        .clk(clk),
        .rst(rst),
        .clr(in_idle),
        .en (state == S_GAP),
        .tc (gap_tc)
      );
    end else begin : g_nogap
      assign gap_tc = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) begin
          if (GAP > 0) state_n = S_GAP;
          else if (!accept) state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_tc) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      order <= 1'b1;
    end else if (accept) begin
      shreg <= din;
      order <= msb_first;
    end else if (in_shift) begin
      shreg <= order ? (shreg << 1) : (shreg >> 1);
    end
  end

  assign x_out = in_shift
               ? (order ? shreg[WIDTH-1] : shreg[0])
               : IDLE_LEVEL;
  assign x_valid   = in_shift;
  assign word_done = last_bit;
  assign busy      = ~in_idle;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench for piso_bit_serializer.
// Two instances: GAP=0 (a_*) and GAP=2 (b_*).
module tb_piso_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] a_din = '0;
  logic       a_valid = 1'b0;
  logic       a_msb = 1'b1;
  logic       a_ready, a_x, a_xv, a_done, a_busy;

  logic [7:0] b_din = '0;
  logic       b_valid = 1'b0;
  logic       b_msb = 1'b1;
  logic       b_ready, b_x, b_xv, b_done, b_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(8), .GAP(0)) dut_a (
    .clk(clk), .rst(rst),
    .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
    .msb_first(a_msb),
    .x_out(a_x), .x_valid(a_xv),
    .word_done(a_done), .busy(a_busy)
  );

  piso_bit_serializer #(.WIDTH(8), .GAP(2)) dut_b (
    .clk(clk), .rst(rst),
    .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
    .msb_first(b_msb),
    .x_out(b_x), .x_valid(b_xv),
    .word_done(b_done), .busy(b_busy)
  );

  // Bit i of the serial stream for word w.
  function automatic logic exp_bit(input logic [7:0] w,
                                   input logic msb,
                                   input int i);
    int sh;
    sh = msb ? (7 - i) : i;
    return logic'((int'(w) >> sh) & 1);
  endfunction

  task automatic chk(input string tag, input logic obs,
                     input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic idle_a(input string tag);
    @(negedge clk);
    chk({tag, "_x"}, a_x, 1'b0);
    chk({tag, "_xv"}, a_xv, 1'b0);
    chk({tag, "_done"}, a_done, 1'b0);
    chk({tag, "_busy"}, a_busy, 1'b0);
    chk({tag, "_rdy"}, a_ready, 1'b1);
  endtask

  task automatic start_a(input logic [7:0] w, input logic msb);
    a_din = w;
    a_msb = msb;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_din = 8'($urandom);
  endtask

  task automatic shift_a(input string tag, input logic [7:0] w,
                         input logic msb, input int nbits,
                         input bit toggle, input int raise_at,
                         input logic [7:0] raise_w,
                         input logic raise_msb);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      chk($sformatf("%s_x%0d", tag, i), a_x, exp_bit(w, msb, i));
      chk($sformatf("%s_xv%0d", tag, i), a_xv, 1'b1);
      chk($sformatf("%s_done%0d", tag, i), a_done, i == 7);
      chk($sformatf("%s_rdy%0d", tag, i), a_ready, i == 7);
      chk($sformatf("%s_busy%0d", tag, i), a_busy, 1'b1);
      @(posedge clk);
      #1;
      if (toggle) a_msb = ~a_msb;
      if (i == raise_at) begin
        a_valid = 1'b1;
        a_din = raise_w;
        a_msb = raise_msb;
      end
    end
  endtask

  // One GAP=2 word: 8 bits, 2 gap cycles, 1 idle cycle.
  task automatic word_b(input int k, input logic [7:0] w,
                        input logic msb, input logic [7:0] nw,
                        input logic nmsb, input bit last);
    b_din = nw;
    b_msb = nmsb;
    b_valid = !last;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 8) begin
        chk($sformatf("b%0d_x%0d", k, i), b_x, exp_bit(w, msb, i));
        chk($sformatf("b%0d_xv%0d", k, i), b_xv, 1'b1);
        chk($sformatf("b%0d_done%0d", k, i), b_done, i == 7);
      end else begin
        chk($sformatf("b%0d_x%0d", k, i), b_x, 1'b0);
        chk($sformatf("b%0d_xv%0d", k, i), b_xv, 1'b0);
        chk($sformatf("b%0d_done%0d", k, i), b_done, 1'b0);
      end
      chk($sformatf("b%0d_rdy%0d", k, i), b_ready, i == 10);
      chk($sformatf("b%0d_busy%0d", k, i), b_busy, i != 10);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] w;
    logic       m;
    logic [7:0] bw[5];
    logic       bm[5];

    // Reset state
    #2;
    idle_a("rst");
    chk("rst_b_x", b_x, 1'b0);
    chk("rst_b_rdy", b_ready, 1'b1);
    chk("rst_b_busy", b_busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: E5 msb-first
    start_a(8'hE5, 1'b1);
    shift_a("t1", 8'hE5, 1'b1, 8, 0, -1, 8'h00, 1'b0);
    idle_a("t1_end");

    // 2: 07 lsb-first, msb_first toggling mid-word
    start_a(8'h07, 1'b0);
    shift_a("t2", 8'h07, 1'b0, 8, 1, -1, 8'h00, 1'b0);
    idle_a("t2_end");

    // 3: back-to-back FF then 00, valid held
    a_din = 8'hFF;
    a_msb = 1'b1;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_din = 8'h00;
    shift_a("t3a", 8'hFF, 1'b1, 8, 0, -1, 8'h00, 1'b0);
    a_valid = 1'b0;
    shift_a("t3b", 8'h00, 1'b1, 8, 0, -1, 8'h00, 1'b0);
    idle_a("t3_end");

    // 6: valid raised mid-word with AA, taken at last bit
    w = 8'($urandom);
    m = 1'($urandom);
    start_a(w, m);
    shift_a("t6a", w, m, 8, 0, 2, 8'hAA, ~m);
    a_valid = 1'b0;
    shift_a("t6b", 8'hAA, ~m, 8, 0, -1, 8'h00, 1'b0);
    idle_a("t6_end");

    // Random standalone words
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom);
      m = 1'($urandom);
      start_a(w, m);
      shift_a($sformatf("r%0d", k), w, m, 8, 0, -1, 8'h00, 1'b0);
    end
    idle_a("rnd_end");

    // 5: reset during bit 4 of E5
    start_a(8'hE5, 1'b1);
    shift_a("t5", 8'hE5, 1'b1, 3, 0, -1, 8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_x", a_x, 1'b0);
    chk("t5_async_xv", a_xv, 1'b0);
    chk("t5_async_done", a_done, 1'b0);
    chk("t5_async_busy", a_busy, 1'b0);
    chk("t5_async_rdy", a_ready, 1'b1);
    @(posedge clk);
    idle_a("t5_held");
    #2;
    rst = 1'b0;
    start_a(8'h0F, 1'b1);
    shift_a("t5b", 8'h0F, 1'b1, 8, 0, -1, 8'h00, 1'b0);
    idle_a("t5_end");

    // 4: GAP=2, valid held over several random words
    for (int k = 0; k < 5; k++) begin
      bw[k] = 8'($urandom);
      bm[k] = 1'($urandom);
    end
    bw[0] = 8'hE5;
    bm[0] = 1'b1;
    b_din = bw[0];
    b_msb = bm[0];
    b_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4)
        word_b(k, bw[k], bm[k], bw[k+1], bm[k+1], 1'b0);
      else
        word_b(k, bw[k], bm[k], 8'h00, 1'b0, 1'b1);
    end
    @(negedge clk);
    chk("t4_end_busy", b_busy, 1'b0);
    chk("t4_end_xv", b_xv, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
